// File: rtl/key_evt_pkg.sv
// Shared constants, key decode and FSM state type for the key event transmitter.
package key_evt_pkg;

    localparam logic [3:0] KEY_S1   = 4'b0001;
    localparam logic [3:0] KEY_S2   = 4'b0010;
    localparam logic [3:0] KEY_S3   = 4'b0100;
    localparam logic [3:0] KEY_S4   = 4'b1000;
    localparam logic [3:0] KEY_NONE = 4'b1111;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned KEY_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAR = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [KEY_IDX_W-1:0] idx;
    } key_evt_t;

    // Only the four one-hot codes are events; everything else is silently ignored.
    function automatic key_evt_t key_decode(input logic [3:0] code);
        key_evt_t evt;
        evt = '0;
        case (code)
            KEY_S1:  evt = '{valid: 1'b1, idx: 2'd0};
            KEY_S2:  evt = '{valid: 1'b1, idx: 2'd1};
            KEY_S3:  evt = '{valid: 1'b1, idx: 2'd2};
            KEY_S4:  evt = '{valid: 1'b1, idx: 2'd3};
            default: evt = '0;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module key_evt_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/key_event_tx.sv
// Queues debounced key pulses and sends one ASCII byte per press over a valid/ready link.
// Optional feature: define KEY_EVT_CRLF_EN to follow every character with CR then LF.
module key_event_tx
    import key_evt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CHAR_BASE  = 8'h31,
    localparam int unsigned LEVEL_W   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               key_clk,
    input  logic               key_rst,
    input  logic [3:0]         key_value,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               overflow,
    output logic [LEVEL_W-1:0] fifo_level
);

    key_evt_t             evt;
    logic [KEY_IDX_W-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 xfer;
    logic [7:0]           load_char;
    state_t               state;
    state_t               state_nxt;
    logic                 tx_valid_nxt;
    logic [7:0]           tx_data_nxt;

    assign evt       = key_decode(key_value);
    assign xfer      = tx_valid && tx_ready;
    assign load_char = CHAR_BASE + 8'(fifo_rdata);

    key_evt_fifo #(
        .WIDTH (KEY_IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (key_clk),
        .rst   (key_rst),
        .push  (evt.valid),
        .pop   (pop),
        .wdata (evt.idx),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge key_clk) begin
        if (key_rst) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
            overflow <= evt.valid && fifo_full && !pop;
        end
    end

    // Next state and next registered outputs; loading a character always pops the FIFO.
    always_comb begin
        state_nxt    = state;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    state_nxt    = ST_CHAR;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = load_char;
                end
            end
            ST_CHAR: begin
                if (xfer) begin
`ifdef KEY_EVT_CRLF_EN
                    state_nxt   = ST_CR;
                    tx_data_nxt = ASCII_CR;
`else
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        tx_data_nxt = load_char;
                    end else begin
                        state_nxt    = ST_IDLE;
                        tx_valid_nxt = 1'b0;
                    end
`endif
                end
            end
`ifdef KEY_EVT_CRLF_EN
            ST_CR: begin
                if (xfer) begin
                    state_nxt   = ST_LF;
                    tx_data_nxt = ASCII_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        state_nxt   = ST_CHAR;
                        tx_data_nxt = load_char;
                    end else begin
                        state_nxt    = ST_IDLE;
                        tx_valid_nxt = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_nxt    = ST_IDLE;
                tx_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_event_tx.sv
// Self-checking bench for key_event_tx: vector table, directed corner sequences and a randomized run against a queue model.
module tb_key_event_tx;

    localparam int DEPTH = 4;
    localparam logic [7:0] BASE = 8'h31;
`ifdef KEY_EVT_CRLF_EN
    localparam int PER = 3;
`else
    localparam int PER = 1;
`endif

    logic       key_clk = 1'b0;
    logic       key_rst;
    logic [3:0] key_value;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       overflow;
    logic [2:0] fifo_level;

    always #5 key_clk = ~key_clk;

    key_event_tx #(
        .FIFO_DEPTH (DEPTH),
        .CHAR_BASE  (BASE)
    ) dut (
        .key_clk    (key_clk),
        .key_rst    (key_rst),
        .key_value  (key_value),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int errors = 0;
    int mq[$];          // model: queued key indices
    logic [7:0] mo[$];  // model: bytes still to be sent for the loaded key, front is on the bus
    logic [7:0] got[$]; // bytes the DUT actually handed over
    logic model_ovf;
    int ovf_seen;
    int peak;

    typedef struct {
        logic [3:0] key;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eo;
        int         el;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract behaviour: a bounded key queue and a list of bytes per press, updated once per clock.
    task automatic model_edge(input logic rst, input logic [3:0] key, input logic rdy, output logic ovf);
        logic evt;
        logic xfer;
        logic pop;
        int   idx;
        int   k;
        ovf = 1'b0;
        if (rst) begin
            mq.delete();
            mo.delete();
            return;
        end
        evt = 1'b1;
        idx = 0;
        case (key)
            4'b0001: idx = 0;
            4'b0010: idx = 1;
            4'b0100: idx = 2;
            4'b1000: idx = 3;
            default: evt = 1'b0;
        endcase
        xfer = (mo.size() > 0) && rdy;
        pop  = (mq.size() > 0) && ((mo.size() == 0) || (xfer && mo.size() == 1));
        if (xfer) void'(mo.pop_front());
        if (pop) begin
            k = mq.pop_front();
            mo.push_back(BASE + 8'(k));
            if (PER == 3) begin
                mo.push_back(8'h0D);
                mo.push_back(8'h0A);
            end
        end
        if (evt) begin
            if (mq.size() < DEPTH) mq.push_back(idx);
            else ovf = 1'b1;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] key, input logic rdy);
        key_rst   = rst;
        key_value = key;
        tx_ready  = rdy;
        if (!rst && tx_valid && rdy) got.push_back(tx_data);
        @(posedge key_clk);
        model_edge(rst, key, rdy, model_ovf);
        #1;
        check("tx_valid", 32'(tx_valid), 32'(mo.size() > 0));
        if (mo.size() > 0) check("tx_data", 32'(tx_data), 32'(mo[0]));
        check("overflow", 32'(overflow), 32'(model_ovf));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        if (overflow) ovf_seen++;
        if (32'(fifo_level) > 32'(peak)) peak = 32'(fifo_level);
    endtask

    task automatic do_reset();
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        got.delete();
        ovf_seen = 0;
        peak = 0;
    endtask

    task automatic check_got(input string name, input int keys[$]);
        int j;
        check({name, "_count"}, 32'(got.size()), 32'(keys.size() * PER));
        for (int i = 0; i < keys.size(); i++) begin
            j = i * PER;
            if (j < got.size()) check({name, "_char"}, 32'(got[j]), 32'(BASE + 8'(keys[i])));
            if (PER == 3 && j + 2 < got.size()) begin
                check({name, "_cr"}, 32'(got[j+1]), 32'h0D);
                check({name, "_lf"}, 32'(got[j+2]), 32'h0A);
            end
        end
    endtask

    initial begin
        vec_t tv[$];
        int   ek[$];
        logic [3:0] bad_codes[7];
        logic [3:0] onehot[4];
        logic [3:0] seq6[6];
        logic       found;
        logic [3:0] k;
        logic       r;

        key_rst   = 1'b1;
        key_value = 4'b1111;
        tx_ready  = 1'b0;
        ovf_seen  = 0;
        peak      = 0;

        // Reset state
        do_reset();
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);

        // Single S3 press, tx_ready held high
        tv.push_back('{4'b0100, 1'b1, 1'b0, 8'h00, 1'b0, 1});
        tv.push_back('{4'b1111, 1'b1, 1'b1, 8'h33, 1'b0, 0});
`ifdef KEY_EVT_CRLF_EN
        tv.push_back('{4'b1111, 1'b1, 1'b1, 8'h0D, 1'b0, 0});
        tv.push_back('{4'b1111, 1'b1, 1'b1, 8'h0A, 1'b0, 0});
`endif
        tv.push_back('{4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 0});
        tv.push_back('{4'b1111, 1'b1, 1'b0, 8'h00, 1'b0, 0});
        for (int i = 0; i < tv.size(); i++) begin
            step(1'b0, tv[i].key, tv[i].rdy);
            check("vec_valid", 32'(tx_valid), 32'(tv[i].ev));
            if (tv[i].ev) check("vec_data", 32'(tx_data), 32'(tv[i].ed));
            check("vec_overflow", 32'(overflow), 32'(tv[i].eo));
            check("vec_level", 32'(fifo_level), 32'(tv[i].el));
        end

        // S1, S2, S4 under a 20-cycle stall
        do_reset();
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 4'b1111, 1'b0);
        check("stall_peak", 32'(peak), 32'd2);
        check("stall_hold_data", 32'(tx_data), 32'h31);
        for (int i = 0; i < 15; i++) step(1'b0, 4'b1111, 1'b1);
        ek = {0, 1, 3};
        check_got("stall", ek);

        // Six back-to-back presses into a stalled link: one dropped
        do_reset();
        seq6 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 6; i++) step(1'b0, seq6[i], 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b0);
        check("ovf_count", 32'(ovf_seen), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, 1'b1);
        ek = {0, 1, 2, 3, 0};
        check_got("ovf", ek);

        // Non-event codes
        do_reset();
        bad_codes = '{4'b0011, 4'b0000, 4'b1111, 4'b0110, 4'b1010, 4'b0111, 4'b1110};
        for (int i = 0; i < 40; i++) step(1'b0, bad_codes[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
        check("inv_level", 32'(fifo_level), 32'd0);
        check("inv_valid", 32'(tx_valid), 32'd0);
        check("inv_ovf", 32'(ovf_seen), 32'd0);

        // Press arriving exactly when a full FIFO is popped
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, seq6[i], 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        check("full_level", 32'(fifo_level), 32'd4);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mq.size() > 0 && mo.size() == 1) begin
                step(1'b0, 4'b0100, 1'b1);
                check("fullpop_ovf", 32'(overflow), 32'd0);
                check("fullpop_level", 32'(fifo_level), 32'd4);
                found = 1'b1;
            end else begin
                step(1'b0, 4'b1111, 1'b1);
            end
        end
        check("fullpop_found", 32'(found), 32'd1);
        for (int i = 0; i < 25; i++) step(1'b0, 4'b1111, 1'b1);
        check("fullpop_ovf_total", 32'(ovf_seen), 32'd0);

        // Reset while a byte is on the bus and three presses are queued
        do_reset();
        onehot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, onehot[i], 1'b0);
            step(1'b0, 4'b1111, 1'b0);
        end
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        step(1'b1, 4'b1111, 1'b0);
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        got.delete();
        step(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b1);
        ek = {1};
        check_got("after_rst", ek);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) k = onehot[$urandom_range(0, 3)];
            else if ($urandom_range(0, 5) == 0) k = 4'($urandom());
            else k = 4'b1111;
            r = ((i / 200) % 2 == 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 499) == 0), k, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
